hub75_framebuf: RTL and testbench
=================================

HUB75_FRAMEBUF -- requirements
Module: hub75_framebuf

Interface
REQ-001 SHALL have parameter COLS, default 64, panel columns; power of two, 64 only in this revision.
REQ-002 SHALL have parameter ROWS, default 64, panel rows; scan is 1/32, so the top half maps to addr and the bottom half to addr+32.
REQ-003 SHALL have port clk, input, 1, single system clock (25 MHz); all logic on the rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port wr_en, input, 1, host pixel write strobe.
REQ-006 SHALL have port wr_x, input, 6, write column 0..63.
REQ-007 SHALL have port wr_y, input, 6, write row 0..63.
REQ-008 SHALL have port wr_rgb, input, 3, write colour {r,g,b}.
REQ-009 SHALL have port clear_req, input, 1, one-cycle pulse that starts a back-buffer clear.
REQ-010 SHALL have port swap_req, input, 1, one-cycle pulse that requests a front/back exchange.
REQ-011 SHALL have port busy, output, 1, high while a clear is in progress.
REQ-012 SHALL have port swap_ack, output, 1, one-cycle pulse in the cycle after the swap takes effect.
REQ-013 SHALL have port rd_en, input, 1, driver read strobe.
REQ-014 SHALL have port rd_addr, input, 5, driver row-pair address 0..31.
REQ-015 SHALL have port rd_col, input, 6, driver column 0..63.
REQ-016 SHALL have port frame_end, input, 1, driver pulse after the latch of row pair 31.
REQ-017 SHALL have port rgb0, output, 3, {r0,g0,b0} for row rd_addr.
REQ-018 SHALL have port rgb1, output, 3, {r1,g1,b1} for row rd_addr+32.
REQ-019 SHALL have port rd_valid, output, 1, rgb0/rgb1 valid for the previous cycle's rd_en.

Function
REQ-020 SHALL hold two banks, each 64x64x3 bit; register front_sel selects the bank the driver reads; the other bank is the back buffer.
REQ-021 SHALL read with 1-cycle latency: rd_en at cycle N -> rgb0/rgb1 from front bank at (rd_addr,rd_col) and (rd_addr+32,rd_col), with rd_valid=1, at cycle N+1.
REQ-022 SHALL hold rgb0/rgb1 at their last value and drive rd_valid=0 in any cycle following rd_en=0.
REQ-023 SHALL, when not busy, write wr_rgb to back bank at (wr_y,wr_x) on wr_en; the write is visible to reads only after a swap.
REQ-024 SHALL never write the front bank; same-coordinate read and write in one cycle cannot conflict.
REQ-025 SHALL implement FSM states IDLE and CLEAR; IDLE->CLEAR on clear_req; CLEAR->IDLE after the last entry is written.
REQ-026 SHALL in CLEAR write 3'b000 to one back-bank entry per cycle via 12-bit counter 0..4095, taking exactly 4096 cycles; busy=1 from the cycle after clear_req through the final write cycle.
REQ-027 SHALL ignore wr_en and clear_req while busy.
REQ-028 SHALL set swap_pending on swap_req; a swap_req while pending SHALL be absorbed (single swap).
REQ-029 SHALL toggle front_sel on the first cycle where swap_pending (or swap_req this cycle) AND frame_end AND NOT busy; it SHALL clear swap_pending and pulse swap_ack the next cycle.
REQ-030 SHALL hold swap_pending across frame_end pulses occurring while busy; the swap occurs at the first frame_end after CLEAR ends.
REQ-031 SHALL take effect for a swap on reads issued in the cycle after the toggle; a read in the toggle cycle SHALL return the old front bank.
REQ-032 SHALL use rd_addr+32 as a 6-bit row with no wrap; rd_addr=31 reads rows 31 and 63.

Reset
REQ-033 SHALL on rst=1 at a clock edge set front_sel=0, state=IDLE, counter=0, swap_pending=0, busy=0, swap_ack=0, rd_valid=0, rgb0=rgb1=0.
REQ-034 SHALL abort a clear in progress on reset; bank contents SHALL be unspecified after reset until written or cleared.
REQ-035 SHALL give reset priority over all simultaneous inputs.

Verification
REQ-036 SHALL check: reset, then clear_req -> busy high for 4096 cycles; swap_req + frame_end -> all 2048 reads return rgb0=rgb1=000.
REQ-037 SHALL check: write (x=5,y=3,rgb=101) and (x=5,y=35,rgb=011); swap on frame_end; read addr=3,col=5 -> rgb0=101, rgb1=011, rd_valid=1 one cycle later.
REQ-038 SHALL check: swap_req issued twice before frame_end -> exactly one swap_ack and one front_sel toggle.
REQ-039 SHALL check: swap_req during clear with frame_end at cycle 100 -> no swap; swap_ack only after the first frame_end following busy falling.
REQ-040 SHALL check: wr_en during busy -> entry remains 000 after clear and swap; rst asserted mid-clear -> busy=0 the next cycle.
REQ-041 SHALL check: read addr=31,col=63 -> rgb1 from row 63; swap_req and frame_end in the same cycle -> swap_ack the next cycle.

Source files
------------

// File: rtl/hub75_framebuf.sv
// Double-buffered 64x64x3 frame store for a 1/32-scan HUB75 panel.
// The host writes and clears the back bank; the driver reads row pairs from the front bank.
module hub75_framebuf #(
  parameter int COLS = 64,
  parameter int ROWS = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [5:0] wr_x,
  input  logic [5:0] wr_y,
  input  logic [2:0] wr_rgb,
  input  logic       clear_req,
  input  logic       swap_req,
  output logic       busy,
  output logic       swap_ack,
  input  logic       rd_en,
  input  logic [4:0] rd_addr,
  input  logic [5:0] rd_col,
  input  logic       frame_end,
  output logic [2:0] rgb0,
  output logic [2:0] rgb1,
  output logic       rd_valid
);

  localparam int HALF = (COLS * ROWS) / 2;

  // state | meaning
  // IDLE  | host writes accepted, clear_req starts a clear
  // CLEAR | one back-bank entry zeroed per cycle, host writes ignored
  typedef enum logic {IDLE, CLEAR} state_t;

  state_t      state_q, state_d;
  logic [11:0] cnt_q, cnt_d;
  logic        front_sel_q, front_sel_d;
  logic        swap_pending_q, swap_pending_d;
  logic        busy_q, busy_d;
  logic        swap_ack_q, swap_ack_d;
  logic        rd_valid_q, rd_valid_d;
  logic [2:0]  rgb0_q, rgb0_d;
  logic [2:0]  rgb1_q, rgb1_d;

  // Each bank is split into top (rows 0..31) and bottom (rows 32..63) halves
  // so both rows of a scan pair come out in the same cycle.
  logic [2:0]  mem_q [0:1][0:1][0:HALF-1];

  logic        back_sel;
  logic        swap_fire;
  logic        mem_we;
  logic        mem_half;
  logic [10:0] mem_idx;
  logic [2:0]  mem_wdata;
  logic [10:0] rd_idx;

  assign back_sel = ~front_sel_q;
  assign rd_idx   = {rd_addr, rd_col};

  always_comb begin
    mem_we    = 1'b0;
    mem_half  = 1'b0;
    mem_idx   = '0;
    mem_wdata = '0;
    if (state_q == CLEAR) begin
      mem_we   = 1'b1;
      mem_half = cnt_q[11];
      mem_idx  = cnt_q[10:0];
    end else if (wr_en) begin
      mem_we    = 1'b1;
      mem_half  = wr_y[5];
      mem_idx   = {wr_y[4:0], wr_x};
      mem_wdata = wr_rgb;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    case (state_q)
      IDLE: begin
        if (clear_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      CLEAR: begin
        cnt_d = cnt_q + 12'd1;
        if (cnt_q == 12'hFFF) begin
          state_d = IDLE;
          cnt_d   = '0;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // A swap_req arriving together with frame_end still fires in that cycle.
  always_comb begin
    swap_fire      = (swap_pending_q | swap_req) & frame_end & ~busy_q;
    front_sel_d    = front_sel_q ^ swap_fire;
    swap_pending_d = swap_fire ? 1'b0 : (swap_pending_q | swap_req);
    swap_ack_d     = swap_fire;
  end

  always_comb begin
    rd_valid_d = rd_en;
    rgb0_d     = rgb0_q;
    rgb1_d     = rgb1_q;
    if (rd_en) begin
      rgb0_d = mem_q[front_sel_q][0][rd_idx];
      rgb1_d = mem_q[front_sel_q][1][rd_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      front_sel_q    <= 1'b0;
      swap_pending_q <= 1'b0;
      busy_q         <= 1'b0;
      swap_ack_q     <= 1'b0;
      rd_valid_q     <= 1'b0;
      rgb0_q         <= '0;
      rgb1_q         <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      front_sel_q    <= front_sel_d;
      swap_pending_q <= swap_pending_d;
      busy_q         <= busy_d;
      swap_ack_q     <= swap_ack_d;
      rd_valid_q     <= rd_valid_d;
      rgb0_q         <= rgb0_d;
      rgb1_q         <= rgb1_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && mem_we) begin
      mem_q[back_sel][mem_half][mem_idx] <= mem_wdata;
    end
  end

  assign busy     = busy_q;
  assign swap_ack = swap_ack_q;
  assign rd_valid = rd_valid_q;
  assign rgb0     = rgb0_q;
  assign rgb1     = rgb1_q;

endmodule

// File: tb/tb_hub75_framebuf.sv
// Bench for hub75_framebuf: a bank-level reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_hub75_framebuf;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [5:0] wr_x = '0;
  logic [5:0] wr_y = '0;
  logic [2:0] wr_rgb = '0;
  logic       clear_req = 1'b0;
  logic       swap_req = 1'b0;
  logic       busy;
  logic       swap_ack;
  logic       rd_en = 1'b0;
  logic [4:0] rd_addr = '0;
  logic [5:0] rd_col = '0;
  logic       frame_end = 1'b0;
  logic [2:0] rgb0;
  logic [2:0] rgb1;
  logic       rd_valid;

  int n_tests = 0;
  int n_fail  = 0;

  hub75_framebuf #(.COLS(64), .ROWS(64)) dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_rgb(wr_rgb),
    .clear_req(clear_req), .swap_req(swap_req),
    .busy(busy), .swap_ack(swap_ack),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_col(rd_col),
    .frame_end(frame_end),
    .rgb0(rgb0), .rgb1(rgb1), .rd_valid(rd_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: banks as plain arrays with a "known" flag; a clear is
  // modelled as wiping the back bank at once plus a 4096-cycle busy window.
  bit [2:0] mb [0:1][0:63][0:63];
  bit       mk [0:1][0:63][0:63];
  bit       m_init = 0;
  bit       m_front, m_pend, m_fire, m_busy_now;
  int       m_left;
  bit       e_busy, e_ack, e_valid, e_k0, e_k1;
  bit [2:0] e_rgb0, e_rgb1;

  always @(posedge clk) begin
    if (rst) begin
      m_init = 1; m_front = 0; m_pend = 0; m_left = 0;
      e_busy = 0; e_ack = 0; e_valid = 0; e_rgb0 = 0; e_rgb1 = 0; e_k0 = 1; e_k1 = 1;
      for (int b = 0; b < 2; b++)
        for (int y = 0; y < 64; y++)
          for (int x = 0; x < 64; x++) mk[b][y][x] = 0;
    end else if (m_init) begin
      m_busy_now = (m_left > 0);
      e_valid = rd_en;
      if (rd_en) begin
        e_rgb0 = mb[m_front][int'(rd_addr)][int'(rd_col)];
        e_k0   = mk[m_front][int'(rd_addr)][int'(rd_col)];
        e_rgb1 = mb[m_front][int'(rd_addr) + 32][int'(rd_col)];
        e_k1   = mk[m_front][int'(rd_addr) + 32][int'(rd_col)];
      end
      if (wr_en && !m_busy_now) begin
        mb[!m_front][int'(wr_y)][int'(wr_x)] = wr_rgb;
        mk[!m_front][int'(wr_y)][int'(wr_x)] = 1;
      end
      m_fire = (m_pend || swap_req) && frame_end && !m_busy_now;
      e_ack  = m_fire;
      if (m_fire) begin m_front = !m_front; m_pend = 0; end
      else m_pend = m_pend || swap_req;
      if (m_busy_now) m_left--;
      else if (clear_req) begin
        m_left = 4096;
        for (int y = 0; y < 64; y++)
          for (int x = 0; x < 64; x++) begin
            mb[!m_front][y][x] = 0;
            mk[!m_front][y][x] = 1;
          end
      end
      e_busy = (m_left > 0);
    end
  end

  always begin
    @(posedge clk);
    #1;
    if (m_init) begin
      chk("busy", busy, e_busy);
      chk("swap_ack", swap_ack, e_ack);
      chk("rd_valid", rd_valid, e_valid);
      if (e_k0) chk("rgb0", rgb0, e_rgb0);
      if (e_k1) chk("rgb1", rgb1, e_rgb1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
    wr_en = 0; clear_req = 0; swap_req = 0; frame_end = 0; rd_en = 0;
  endtask

  task automatic wr(input int x, input int y, input int c);
    wr_en = 1; wr_x = 6'(x); wr_y = 6'(y); wr_rgb = 3'(c);
    tick();
  endtask

  task automatic rd(input int a, input int c);
    rd_en = 1; rd_addr = 5'(a); rd_col = 6'(c);
    tick();
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 5000) begin n++; tick(); end
    if (n >= 5000) chk(name, 1, 0);
  endtask

  task automatic do_clear();
    clear_req = 1; tick(); wait_idle("clear_timeout");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, err, acks;
    tick(); tick();
    rst = 0;
    chk("reset_busy", busy, 0);
    chk("reset_valid", rd_valid, 0);
    chk("reset_rgb0", rgb0, 0);
    chk("reset_ack", swap_ack, 0);

    // clear: busy for exactly 4096 cycles, then swap and read every entry
    clear_req = 1; tick();
    n = 0;
    while (busy && n < 5000) begin n++; tick(); end
    chk("clear_busy_cycles", n, 4096);
    swap_req = 1; frame_end = 1; tick();
    chk("swap_after_clear_ack", swap_ack, 1);
    err = 0;
    for (int a = 0; a < 32; a++)
      for (int c = 0; c < 64; c++) begin
        rd(a, c);
        if (rgb0 != 0 || rgb1 != 0 || !rd_valid) err++;
      end
    chk("clear_reads_bad", err, 0);
    do_clear();

    // writes land in the back bank, appear only after the swap
    wr(5, 3, 3'b101);
    wr(5, 35, 3'b011);
    rd(3, 5);
    chk("pre_swap_rgb0", rgb0, 0);
    swap_req = 1; frame_end = 1; rd_en = 1; rd_addr = 3; rd_col = 5; tick();
    chk("toggle_cycle_read_old", rgb0, 0);
    chk("toggle_ack", swap_ack, 1);
    rd(3, 5);
    chk("swap_rgb0", rgb0, 3'b101);
    chk("swap_rgb1", rgb1, 3'b011);
    chk("swap_valid", rd_valid, 1);
    tick();
    chk("idle_valid_low", rd_valid, 0);
    chk("idle_rgb0_held", rgb0, 3'b101);
    wr_en = 1; wr_x = 5; wr_y = 3; wr_rgb = 3'b110; rd_en = 1; rd_addr = 3; rd_col = 5; tick();
    chk("same_coord_rgb0", rgb0, 3'b101);

    // double swap_req before frame_end -> one swap
    acks = 0;
    swap_req = 1; tick(); acks += swap_ack;
    swap_req = 1; tick(); acks += swap_ack;
    repeat (3) begin tick(); acks += swap_ack; end
    frame_end = 1; tick(); acks += swap_ack;
    repeat (3) begin frame_end = 1; tick(); acks += swap_ack; end
    chk("double_req_acks", acks, 1);
    rd(3, 5);
    chk("double_req_front", rgb0, 3'b110);

    // swap_req during clear, frame_end at busy cycle 100 -> deferred
    clear_req = 1; tick();
    swap_req = 1; tick();
    n = 2; acks = 0;
    while (busy && n < 5000) begin
      if (n == 100) frame_end = 1;
      acks += swap_ack;
      tick(); n++;
    end
    chk("busy_swap_acks", acks, 0);
    tick(); tick();
    chk("pending_no_ack", swap_ack, 0);
    frame_end = 1; tick();
    chk("deferred_ack", swap_ack, 1);
    rd(3, 5);
    chk("deferred_rgb0", rgb0, 0);
    chk("deferred_rgb1", rgb1, 0);

    // write during busy is dropped (entry 583 is cleared before cycle 1000)
    clear_req = 1; tick();
    n = 1;
    while (busy && n < 5000) begin
      if (n == 1000) begin wr_en = 1; wr_x = 7; wr_y = 9; wr_rgb = 3'b111; end
      tick(); n++;
    end
    swap_req = 1; frame_end = 1; tick();
    rd(9, 7);
    chk("busy_write_dropped", rgb0, 0);

    // reset mid-clear
    clear_req = 1; tick();
    repeat (50) tick();
    chk("mid_clear_busy", busy, 1);
    rst = 1; tick();
    chk("rst_abort_busy", busy, 0);
    rst = 0;

    // last row pair and same-cycle swap_req + frame_end
    wr(63, 31, 3'b001);
    wr(63, 63, 3'b110);
    swap_req = 1; frame_end = 1; tick();
    chk("same_cycle_ack", swap_ack, 1);
    rd(31, 63);
    chk("last_rgb0", rgb0, 3'b001);
    chk("last_rgb1", rgb1, 3'b110);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
